sdram_slot_arbiter: RTL and testbench
=====================================

# sdram_slot_arbiter

- Shares the single read/write port of the SDRAM controller between two `clk_cpu`-domain requesters, A (CPU) and B (video/PPU).
- Generates the slot clock-enable and the one-cycle request pulse that the controller expects.
- Grants by fixed priority to B, with a starvation limit that guarantees A a slot.
- Returns acknowledge and read data to the granted requester.
- Sits between the requesters and the controller's `we/addr/din/req/ds/dout` port, replacing the ad-hoc divider/edge-detect request logic in top levels.

## Interface
Parameters:
- SLOT_CYCLES, 8 — `clk_cpu` cycles per access slot; power of two, ≥4.
- RD_SLOTS, 1 — slots after the issuing slot at which read data is valid; range 1..3.
- B_BURST, 3 — maximum consecutive B grants while A is waiting.

Ports:
- clk_cpu  in  1  system clock.
- reset  in  1  synchronous, active-high.
- a_req  in  1  A request level; held, with fields stable, until a_ack.
- a_we  in  1  A write (1) / read (0).
- a_addr  in  24  A word address.
- a_din  in  16  A write data.
- a_ds  in  2  A byte selects.
- a_ack  out  1  one-cycle completion pulse.
- a_dout  out  16  A read data, valid with a_ack.
- b_req, b_we, b_addr, b_din, b_ds, b_ack, b_dout — same as A.
- sd_clk_en  out  1  controller clock enable.
- sd_req  out  1  one-cycle request pulse.
- sd_we  out  1  to controller.
- sd_addr  out  24  to controller.
- sd_din  out  16  to controller.
- sd_ds  out  2  to controller.
- sd_dout  in  16  controller read data.

## Operation
- Slot counter `cnt` (log2 SLOT_CYCLES bits):
  - increments every cycle and wraps.
  - sd_clk_en = `cnt` MSB, i.e. high for the second half of each slot.
- Arbitration occurs on the edge ending cycle `cnt`==SLOT_CYCLES/2−1 (H−1). It is skipped if a read is outstanding.
  - Only B requesting → grant B.
  - Only A requesting → grant A.
  - Both requesting → grant B, unless `streak`==B_BURST, in which case grant A.
  - `streak` increments on each B grant made while a_req is high.
  - `streak` clears on any A grant, or when a_req is low at arbitration.
  - No request → idle slot; sd_req stays low.
- Issue: sd_req is high for exactly the cycle `cnt`==H. During that cycle sd_we/sd_addr/sd_din/sd_ds carry the registered fields of the granted port.
  - Fields hold until the next grant.
  - sd_we is 0 whenever no transaction is in flight.
- Completion: xx_ack and xx_dout are asserted during cycle `cnt`==SLOT_CYCLES−1.
  - Write: completes in the issuing slot N; xx_dout is unchanged.
  - Read: completes in slot N+RD_SLOTS. xx_dout = sd_dout registered on the preceding edge. A single read is outstanding at a time, so no grant is made until the completion slot has ended.
- Only the granted port's ack pulses. a_ack and b_ack are never high together.
- A requester whose req is still high at the next arbitration point is presenting a new transaction.

## Timing
- Reset values:
  - `cnt`=0, `streak`=0, no grant, no outstanding read.
  - All outputs 0.
- Reset asserted mid-transaction drops it: no ack is ever issued for it, and sd_req is forced low.
- Latency from req sampled to ack, in cycles (SLOT_CYCLES=8):
  - Write: 4.
  - Read, RD_SLOTS=1: 12.
- Throughput:
  - Writes: one per slot.
  - Reads: one per (RD_SLOTS+1) slots.
- Request rising at `cnt`==H−1 is sampled that edge. Rising at `cnt`==H waits a full slot.

## Test plan
- SLOT_CYCLES=8: A write only, addr 0x000010, din 0x00A5, raised at `cnt`=0 → sd_req at `cnt`=4 with those fields, sd_we=1; a_ack at `cnt`=7 of the same slot; sd_clk_en high `cnt` 4..7.
- A read, sd_dout=0x1234 during slot N+1 → no sd_req in slot N+1; a_ack with a_dout=0x1234 at `cnt`=7 of slot N+1; next A read issued no earlier than slot N+2.
- A and B both write continuously, B_BURST=3 → grant order B,B,B,A,B,B,B,A; no two acks in the same cycle.
- B alone → streak stays 0; A then arrives → A served within B_BURST+1 slots.
- Reset pulsed at `cnt`=5 of a read's issue slot → no ack; outputs 0; next request is issued normally with `cnt` restarting from 0.
- No requests for 4 slots → sd_req never high; sd_clk_en keeps toggling with period 8.

Source files
------------

// File: rtl/sdram_slot_arbiter.sv
// Two-requester slot arbiter in front of the SDRAM controller port.
// Generates slot clock-enable and request pulse; B has priority with a starvation limit for A.
module sdram_slot_arbiter #(
  parameter int unsigned SLOT_CYCLES = 8,
  parameter int unsigned RD_SLOTS    = 1,
  parameter int unsigned B_BURST     = 3
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [23:0] a_addr,
  input  logic [15:0] a_din,
  input  logic [1:0]  a_ds,
  output logic        a_ack,
  output logic [15:0] a_dout,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [23:0] b_addr,
  input  logic [15:0] b_din,
  input  logic [1:0]  b_ds,
  output logic        b_ack,
  output logic [15:0] b_dout,
  output logic        sd_clk_en,
  output logic        sd_req,
  output logic        sd_we,
  output logic [23:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_ds,
  input  logic [15:0] sd_dout
);

  localparam int unsigned CW   = $clog2(SLOT_CYCLES);
  localparam int unsigned HALF = SLOT_CYCLES / 2;
  localparam int unsigned SW   = $clog2(B_BURST + 2);
  localparam int unsigned LW   = 2;
  localparam int unsigned AW   = 24;
  localparam int unsigned DW   = 16;
  localparam int unsigned BW   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [LW-1:0]   left_q, left_d;
  logic            txn_b_q, txn_b_d;
  logic            sd_req_q, sd_req_d;
  logic            sd_we_q, sd_we_d;
  logic [AW-1:0]   sd_addr_q, sd_addr_d;
  logic [DW-1:0]   sd_din_q, sd_din_d;
  logic [BW-1:0]   sd_ds_q, sd_ds_d;
  logic            a_ack_q, a_ack_d;
  logic [DW-1:0]   a_dout_q, a_dout_d;
  logic            b_ack_q, b_ack_d;
  logic [DW-1:0]   b_dout_q, b_dout_d;

  logic            arb_pt, cmpl_pt, wrap_pt;
  logic            grant_a, grant_b, sel_we;

  // Slot phase markers; arbitration is suppressed while a read is outstanding
  always_comb begin
    arb_pt  = (cnt_q == CW'(HALF - 1)) && (state_q == ST_IDLE);
    cmpl_pt = (cnt_q == CW'(SLOT_CYCLES - 2)) && (state_q != ST_IDLE) && (left_q == '0);
    wrap_pt = (cnt_q == CW'(SLOT_CYCLES - 1));
  end

  // Fixed priority to B, except A wins once B has used up its burst allowance
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (arb_pt) begin
      if (a_req && (!b_req || (streak_q == SW'(B_BURST)))) begin
        grant_a = 1'b1;
      end else if (b_req) begin
        grant_b = 1'b1;
      end
    end
    sel_we = grant_b ? b_we : a_we;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    streak_d  = streak_q;
    left_d    = left_q;
    txn_b_d   = txn_b_q;
    sd_req_d  = 1'b0;
    sd_we_d   = sd_we_q;
    sd_addr_d = sd_addr_q;
    sd_din_d  = sd_din_q;
    sd_ds_d   = sd_ds_q;
    a_ack_d   = 1'b0;
    a_dout_d  = a_dout_q;
    b_ack_d   = 1'b0;
    b_dout_d  = b_dout_q;

    if (arb_pt) begin
      if (!a_req || grant_a) begin
        streak_d = '0;
      end else if (grant_b) begin
        streak_d = streak_q + SW'(1);
      end
    end

    if (grant_a || grant_b) begin
      state_d   = sel_we ? ST_WR : ST_RD;
      left_d    = sel_we ? LW'(0) : LW'(RD_SLOTS);
      txn_b_d   = grant_b;
      sd_req_d  = 1'b1;
      sd_we_d   = sel_we;
      sd_addr_d = grant_b ? b_addr : a_addr;
      sd_din_d  = grant_b ? b_din  : a_din;
      sd_ds_d   = grant_b ? b_ds   : a_ds;
    end

    // Slot boundary: writes are done, reads move one slot closer to completion
    if (wrap_pt) begin
      sd_we_d = 1'b0;
      if ((state_q == ST_RD) && (left_q != '0)) begin
        left_d = left_q - LW'(1);
      end
    end

    if (cmpl_pt) begin
      state_d = ST_IDLE;
      if (txn_b_q) begin
        b_ack_d = 1'b1;
        if (state_q == ST_RD) b_dout_d = sd_dout;
      end else begin
        a_ack_d = 1'b1;
        if (state_q == ST_RD) a_dout_d = sd_dout;
      end
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      streak_q  <= '0;
      left_q    <= '0;
      txn_b_q   <= 1'b0;
      sd_req_q  <= 1'b0;
      sd_we_q   <= 1'b0;
      sd_addr_q <= '0;
      sd_din_q  <= '0;
      sd_ds_q   <= '0;
      a_ack_q   <= 1'b0;
      a_dout_q  <= '0;
      b_ack_q   <= 1'b0;
      b_dout_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      streak_q  <= streak_d;
      left_q    <= left_d;
      txn_b_q   <= txn_b_d;
      sd_req_q  <= sd_req_d;
      sd_we_q   <= sd_we_d;
      sd_addr_q <= sd_addr_d;
      sd_din_q  <= sd_din_d;
      sd_ds_q   <= sd_ds_d;
      a_ack_q   <= a_ack_d;
      a_dout_q  <= a_dout_d;
      b_ack_q   <= b_ack_d;
      b_dout_q  <= b_dout_d;
    end
  end

  assign sd_clk_en = cnt_q[CW-1];
  assign sd_req    = sd_req_q;
  assign sd_we     = sd_we_q;
  assign sd_addr   = sd_addr_q;
  assign sd_din    = sd_din_q;
  assign sd_ds     = sd_ds_q;
  assign a_ack     = a_ack_q;
  assign a_dout    = a_dout_q;
  assign b_ack     = b_ack_q;
  assign b_dout    = b_dout_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed bench for sdram_slot_arbiter at SLOT_CYCLES=8, RD_SLOTS=1, B_BURST=3.
module tb_sdram_slot_arbiter;

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [23:0] a_addr, b_addr;
  logic [15:0] a_din, b_din;
  logic [1:0]  a_ds, b_ds;
  logic        a_ack, b_ack;
  logic [15:0] a_dout, b_dout;
  logic        sd_clk_en, sd_req, sd_we;
  logic [23:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_ds;
  logic [15:0] sd_dout;

  int nvec = 0;
  int nerr = 0;
  int tcnt = 0;

  localparam logic [23:0] A_ADDR = 24'h00000A;
  localparam logic [23:0] B_ADDR = 24'h00000B;

  sdram_slot_arbiter #(.SLOT_CYCLES(8), .RD_SLOTS(1), .B_BURST(3)) dut (
    .clk_cpu(clk_cpu), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_ds(a_ds),
    .a_ack(a_ack), .a_dout(a_dout),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_ds(b_ds),
    .b_ack(b_ack), .b_dout(b_dout),
    .sd_clk_en(sd_clk_en), .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr),
    .sd_din(sd_din), .sd_ds(sd_ds), .sd_dout(sd_dout)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; tcnt follows the expected slot counter, checks run at the falling edge
  task automatic tick();
    @(posedge clk_cpu);
    tcnt = reset ? 0 : (tcnt + 1) % 8;
    @(negedge clk_cpu);
    chk("ack_exclusive", {31'd0, a_ack & b_ack}, 32'd0);
  endtask

  task automatic to_cnt(input int c);
    for (int n = 0; n < 8 && tcnt != c; n++) tick();
  endtask

  task automatic check_slot(input bit exp_b, input string tag);
    to_cnt(4);
    chk({tag, "_req"}, {31'd0, sd_req}, 32'd1);
    chk({tag, "_addr"}, {8'd0, sd_addr}, {8'd0, exp_b ? B_ADDR : A_ADDR});
    to_cnt(7);
    chk({tag, "_a_ack"}, {31'd0, a_ack}, {31'd0, !exp_b});
    chk({tag, "_b_ack"}, {31'd0, b_ack}, {31'd0, exp_b});
  endtask

  initial begin
    int bad_req, bad_ack, bad_en;
    bit order [8];
    order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0; a_ds = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0; b_ds = '0;
    sd_dout = '0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_clk_en", {31'd0, sd_clk_en}, 32'd0);
    chk("rst_sd_req", {31'd0, sd_req}, 32'd0);
    chk("rst_sd_we", {31'd0, sd_we}, 32'd0);
    chk("rst_sd_addr", {8'd0, sd_addr}, 32'd0);
    chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
    chk("rst_a_dout", {16'd0, a_dout}, 32'd0);
    reset = 1'b0;

    // A write raised at cnt 0
    a_req = 1'b1; a_we = 1'b1; a_addr = 24'h000010; a_din = 16'h00A5; a_ds = 2'b11;
    to_cnt(3);
    chk("wr_req_c3", {31'd0, sd_req}, 32'd0);
    chk("wr_en_c3", {31'd0, sd_clk_en}, 32'd0);
    to_cnt(4);
    chk("wr_req_c4", {31'd0, sd_req}, 32'd1);
    chk("wr_we_c4", {31'd0, sd_we}, 32'd1);
    chk("wr_addr_c4", {8'd0, sd_addr}, 32'h10);
    chk("wr_din_c4", {16'd0, sd_din}, 32'hA5);
    chk("wr_ds_c4", {30'd0, sd_ds}, 32'd3);
    chk("wr_en_c4", {31'd0, sd_clk_en}, 32'd1);
    to_cnt(5);
    chk("wr_req_c5", {31'd0, sd_req}, 32'd0);
    to_cnt(7);
    chk("wr_a_ack_c7", {31'd0, a_ack}, 32'd1);
    chk("wr_b_ack_c7", {31'd0, b_ack}, 32'd0);
    chk("wr_en_c7", {31'd0, sd_clk_en}, 32'd1);
    a_req = 1'b0;
    to_cnt(0);
    chk("wr_ack_off", {31'd0, a_ack}, 32'd0);
    chk("wr_we_off", {31'd0, sd_we}, 32'd0);
    chk("wr_addr_hold", {8'd0, sd_addr}, 32'h10);

    // A read: data returns one slot later, next read only in slot N+2
    a_req = 1'b1; a_we = 1'b0; a_addr = 24'h000020; sd_dout = 16'hDEAD;
    to_cnt(4);
    chk("rd_req_n", {31'd0, sd_req}, 32'd1);
    chk("rd_we_n", {31'd0, sd_we}, 32'd0);
    chk("rd_addr_n", {8'd0, sd_addr}, 32'h20);
    to_cnt(7);
    chk("rd_no_ack_n", {31'd0, a_ack}, 32'd0);
    to_cnt(0);
    sd_dout = 16'h1234;
    to_cnt(4);
    chk("rd_no_req_n1", {31'd0, sd_req}, 32'd0);
    to_cnt(7);
    chk("rd_ack_n1", {31'd0, a_ack}, 32'd1);
    chk("rd_dout_n1", {16'd0, a_dout}, 32'h1234);
    a_addr = 24'h000022; sd_dout = 16'h5555;
    to_cnt(4);
    chk("rd2_req_n2", {31'd0, sd_req}, 32'd1);
    chk("rd2_addr_n2", {8'd0, sd_addr}, 32'h22);
    chk("rd_dout_hold", {16'd0, a_dout}, 32'h1234);

    // Reset at cnt 5 of the second read's issue slot drops it
    to_cnt(5);
    reset = 1'b1; a_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("mid_rst_sd_we", {31'd0, sd_we}, 32'd0);
    chk("mid_rst_sd_addr", {8'd0, sd_addr}, 32'd0);
    chk("mid_rst_a_dout", {16'd0, a_dout}, 32'd0);
    chk("mid_rst_clk_en", {31'd0, sd_clk_en}, 32'd0);

    // Four idle slots: no request, no ack, clock enable high for cnt 4..7
    bad_req = 0; bad_ack = 0; bad_en = 0;
    for (int i = 0; i < 32; i++) begin
      if (sd_req) bad_req++;
      if (a_ack || b_ack) bad_ack++;
      if (sd_clk_en !== (tcnt >= 4)) bad_en++;
      tick();
    end
    chk("idle_sd_req", bad_req, 32'd0);
    chk("idle_ack", bad_ack, 32'd0);
    chk("idle_clk_en", bad_en, 32'd0);

    // B alone after reset
    b_req = 1'b1; b_we = 1'b1; b_addr = B_ADDR; b_din = 16'hBBBB; b_ds = 2'b01;
    check_slot(1'b1, "b_only");
    b_req = 1'b0;

    // Both write continuously
    a_req = 1'b1; a_we = 1'b1; a_addr = A_ADDR; a_din = 16'hAAAA;
    to_cnt(0);
    b_req = 1'b1;
    for (int s = 0; s < 8; s++) check_slot(order[s], $sformatf("burst%0d", s));
    a_req = 1'b0;

    // B alone for two slots leaves streak at 0; A then served on the fourth slot
    check_slot(1'b1, "solo0");
    check_slot(1'b1, "solo1");
    to_cnt(0);
    a_req = 1'b1;
    for (int s = 0; s < 4; s++) check_slot(order[s], $sformatf("late%0d", s));
    a_req = 1'b0; b_req = 1'b0;

    // Request rising at cnt 3 is taken; rising at cnt 4 waits a full slot
    to_cnt(3);
    a_req = 1'b1; a_addr = 24'h000033;
    to_cnt(4);
    chk("edge_h1_req", {31'd0, sd_req}, 32'd1);
    chk("edge_h1_addr", {8'd0, sd_addr}, 32'h33);
    to_cnt(7);
    chk("edge_h1_ack", {31'd0, a_ack}, 32'd1);
    a_req = 1'b0;
    to_cnt(4);
    a_req = 1'b1; a_addr = 24'h000044;
    chk("edge_h_no_req", {31'd0, sd_req}, 32'd0);
    tick();
    to_cnt(4);
    chk("edge_h_req", {31'd0, sd_req}, 32'd1);
    chk("edge_h_addr", {8'd0, sd_addr}, 32'h44);
    to_cnt(7);
    chk("edge_h_ack", {31'd0, a_ack}, 32'd1);
    a_req = 1'b0;
    to_cnt(0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
